// File: rtl/rom_word_reader_if.sv
// rom_word_reader_if: request, ROM byte bus and 64-bit word stream of rom_word_reader.
// master = reader side, slave = environment (requester, ROM, stream sink).
interface rom_word_reader_if #(
   parameter int ADDR_W = 6
);
   logic              start;
   logic [2:0]        start_word;
   logic [3:0]        num_words;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rom_ad;
   logic [7:0]        rom_d;
   logic [63:0]       out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [63:0]       checksum;
   modport master (
      input  start, start_word, num_words, rom_d, out_ready,
      output busy, done, rom_ad, out_data, out_valid, out_last, checksum
   );
   modport slave (
      output start, start_word, num_words, rom_d, out_ready,
      input  busy, done, rom_ad, out_data, out_valid, out_last, checksum
   );
endinterface

// File: rtl/rom_word_reader.sv
// rom_word_reader: reads 1..8 wrapping 64-bit words from a byte-wide ROM onto a valid/ready stream.
// Define ROM_RD_CHECKSUM_EN to build the running XOR checksum of delivered words.
module rom_word_reader #(
   parameter int ROM_LAT = 1,
   parameter int ADDR_W  = 6
) (
   input logic               clk,
   input logic               rst_n,
   rom_word_reader_if.master bus
);
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;
   state_t                  state_q, state_d;
   logic [2:0]              word_q, word_d, k_q, k_d;
   logic [3:0]              rem_q, rem_d;
   logic [ROM_LAT-1:0]      pv_q, pv_d;
   logic [ROM_LAT-1:0][2:0] po_q, po_d;
   logic [ADDR_W-1:0]       ad_q, ad_d;
   logic [63:0]             data_q, data_d;
   logic                    valid_q, valid_d, last_q, last_d, done_q, done_d;
   logic                    accept, hs;
   assign accept        = state_q == IDLE && bus.start && bus.num_words != 4'd0;
   assign hs            = valid_q && bus.out_ready;
   assign bus.busy      = state_q != IDLE;
   assign bus.done      = done_q;
   assign bus.rom_ad    = ad_q;
   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_q;
   assign bus.out_last  = last_q;
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      k_d     = k_q;
      rem_d   = rem_q;
      ad_d    = ad_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      done_d  = 1'b0;
      pv_d    = '0;
      po_d    = '0;
      pv_d[0] = state_q == FETCH;
      po_d[0] = k_q;
      for (int i = 1; i < ROM_LAT; i++) begin
         pv_d[i] = pv_q[i-1];
         po_d[i] = po_q[i-1];
      end
      // byte k lands in lane 7-k, so byte 0 ends up in the top bits
      if (pv_q[ROM_LAT-1]) data_d[{~po_q[ROM_LAT-1], 3'b000} +: 8] = bus.rom_d;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = FETCH;
               word_d  = bus.start_word;
               rem_d   = bus.num_words;
               k_d     = 3'd0;
               ad_d    = ADDR_W'({bus.start_word, 3'b000});
            end else if (bus.start) done_d = 1'b1;
         end
         FETCH: begin
            k_d = k_q + 3'd1;
            if (k_q == 3'd7) state_d = DRAIN;
            else ad_d = ADDR_W'({word_q, k_q + 3'd1});
         end
         DRAIN: begin
            if (pv_q[ROM_LAT-1] && po_q[ROM_LAT-1] == 3'd7) begin
               state_d = HOLD;
               valid_d = 1'b1;
               last_d  = rem_q == 4'd1;
            end
         end
         HOLD: begin
            if (hs) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               rem_d   = rem_q - 4'd1;
               if (rem_q == 4'd1) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  word_d  = word_q + 3'd1;
                  ad_d    = ADDR_W'({word_q + 3'd1, 3'b000});
                  state_d = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         word_q  <= '0;
         k_q     <= '0;
         rem_q   <= '0;
         pv_q    <= '0;
         po_q    <= '0;
         ad_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         k_q     <= k_d;
         rem_q   <= rem_d;
         pv_q    <= pv_d;
         po_q    <= po_d;
         ad_q    <= ad_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end
`ifdef ROM_RD_CHECKSUM_EN
   logic [63:0] csum_q, csum_d;
   always_comb csum_d = accept ? 64'h0 : hs ? csum_q ^ data_q : csum_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) csum_q <= '0;
      else csum_q <= csum_d;
   end
   assign bus.checksum = csum_q;
`else
   assign bus.checksum = 64'h0;
`endif
endmodule

// File: doc/rom_word_reader.md
Name: rom_word_reader

Overview:
- Sequencer and assembler that sits in front of the 8x64-bit byte-addressed dual_rom.
- Drives the ROM's 6-bit byte address, captures the registered 8-bit byte it returns, and packs 8 bytes into one 64-bit word.
- Delivers words over a valid/ready stream to downstream logic.
- A single start request reads 1..8 consecutive words, with the word index wrapping.

Parameters:
- ROM_LAT, 1, cycles from rom_ad driven to matching byte on rom_d (dual_rom registers its output, so 1); legal 1..4.
- ADDR_W, 6, ROM byte-address width; upper 3 bits are the word index, lower 3 bits are the byte-in-word.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- start_word  in  3  first word index.
- num_words  in  4  words to read, 1..8; 0 means a no-op.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the request completes.
- rom_ad  out  ADDR_W  byte address to the ROM.
- rom_d  in  8  byte returned by the ROM.
- out_data  out  64  assembled word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word.
- out_last  out  1  marks the final word of the request; qualified by out_valid.
- checksum  out  64  running XOR of delivered words (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, out_valid, out_last = 0; rom_ad = 0; out_data = 0; checksum = 0; internal counters and latency pipe cleared.
- States: IDLE, FETCH, DRAIN, HOLD.
- IDLE:
  - start with num_words != 0: latch word_idx = start_word and remaining = num_words, clear byte counter, go to FETCH.
  - start with num_words == 0: pulse done next cycle, stay IDLE.
  - Start is ignored when not in IDLE.
- FETCH: 8 consecutive cycles. In cycle k (k = 0..7), rom_ad = {word_idx, k[2:0]}. A valid/offset tag enters a ROM_LAT-deep pipe alongside each address. After k = 7, go to DRAIN.
- Byte capture: when a tag exits the pipe, rom_d is written into out_data byte lane 7-k, i.e. bits [63-8k -: 8]. Byte 0 lands in [63:56], matching the ROM packing.
- DRAIN: waits until the tag for byte 7 is captured. out_valid rises the cycle after that capture, and the state goes to HOLD.
  - Fetch issued in cycles c..c+7 gives out_valid high from cycle c+8+ROM_LAT (c+9 for ROM_LAT = 1).
- HOLD:
  - out_valid = 1. out_data and out_last stay stable until handshake.
  - out_last = 1 when remaining == 1.
  - On out_valid && out_ready: out_valid drops next cycle and remaining decrements.
    - If words remain: word_idx increments with wrap (7 -> 0) and FETCH restarts the cycle after the handshake.
    - Otherwise: done pulses for one cycle, state returns to IDLE, and busy drops in the same cycle as done.
- rom_ad holds its last value outside FETCH.
- out_ready held low: HOLD indefinitely, no further ROM reads issued (no overrun possible).
- out_ready high with out_valid low: no effect.
- Reset asserted mid-request: immediate abort to reset values. Partial words are discarded and no done pulse is generated.

Optional Feature:
- Macro: ROM_RD_CHECKSUM_EN.
- Defined:
  - checksum clears to 0 when a request is accepted in IDLE.
  - Each handshaken word is XORed in on the handshake edge.
  - The final value is stable from the done pulse until the next accepted start.
- Undefined: checksum is tied to 64'h0 and no checksum register is built.

Test Plan:
Bench uses a ROM_LAT = 1 dual_rom model with word0..7 = 1, 2, 3, 4, 5, 6, 12h, 11301h.
- start_word = 7, num_words = 1, out_ready = 1:
  - rom_ad = 56..63 on consecutive cycles.
  - out_data = 64'h0000000000011301, out_last = 1.
  - out_valid 9 cycles after FETCH start; done one cycle after the handshake.
- start_word = 6, num_words = 3, out_ready = 1:
  - words 64'h12, 64'h11301, 64'h1 in order (wrap 7 -> 0).
  - out_last only on the third word.
  - with ROM_RD_CHECKSUM_EN, checksum = 64'h11312.
- start_word = 0, num_words = 2, out_ready low for 20 cycles after first out_valid:
  - out_data = 1 held stable.
  - rom_ad frozen at 7, no second fetch.
  - release gives a second word of 2.
- num_words = 0: done pulses the next cycle, busy never asserts, no out_valid.
- start pulsed during an active 2-word request: ignored, exactly 2 words delivered.
- rst_n low during FETCH of word 3:
  - all outputs 0 immediately, no done.
  - a subsequent start_word = 3, num_words = 1 returns 64'h4.
